can_fx_scheduler: RTL and testbench

- Sequences the CAN feature-extraction path. Frames from the CAN receiver are buffered in a small FIFO.
- Frames are issued one at a time to feature_extractor as a 1-cycle frame_valid pulse. The block then waits for features_ready and starts the downstream decision-tree classifier, waiting for its done before issuing the next frame.
- It also handles overflow drops, extractor timeouts and frame normalisation (ID masking, DLC clamp).

---
 rtl/can_fx_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_can_fx_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_fx_scheduler.sv
// can_fx_scheduler
//   Buffers received CAN frames in a small FIFO and issues them one at a time
//   to the feature extractor. After the extractor reports features_ready the
//   decision-tree classifier is started, and the next frame is issued only
//   once the classifier reports done. Frames are normalised on issue: 11-bit
//   IDs are masked and the DLC is clamped to 8. Overflow drops and
//   extractor timeouts are counted with saturating counters.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   in_valid/in_*       frame strobe and fields from the CAN receiver
//   fx_can_*            normalised frame to the extractor (held until next pop)
//   fx_frame_extended   extended flag to the extractor
//   fx_frame_valid      1-cycle launch pulse to the extractor
//   fx_features_ready   extractor completion
//   cls_start/cls_done  classifier start pulse / completion
//   sched_busy          scheduler not idle
//   fifo_count          FIFO occupancy
//   drop_cnt            frames dropped on full FIFO (saturating)
//   timeout_cnt         extractor timeouts (saturating)
//   err_timeout         1-cycle pulse on extractor timeout
module can_fx_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [28:0]                   in_id,
  input  logic [3:0]                    in_dlc,
  input  logic [63:0]                   in_data,
  input  logic                          in_extended,
  output logic [28:0]                   fx_can_id,
  output logic [3:0]                    fx_can_dlc,
  output logic [63:0]                   fx_can_data,
  output logic                          fx_frame_extended,
  output logic                          fx_frame_valid,
  input  logic                          fx_features_ready,
  output logic                          cls_start,
  input  logic                          cls_done,
  output logic                          sched_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [CNT_W-1:0]              timeout_cnt,
  output logic                          err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = 29 + 4 + 64 + 1;
  localparam logic [AW:0]   FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_FX,
    CLASSIFY,
    WAIT_CLS
  } state_t;

  state_t state, state_next;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;

  logic          push, pop, drop, timeout_hit;
  logic          fv_next, cls_next, busy_next;

  logic [EW-1:0] head;
  logic [28:0]   head_id;
  logic [3:0]    head_dlc;
  logic [63:0]   head_data;
  logic          head_ext;

  assign head = mem[rd_ptr];
  assign {head_id, head_dlc, head_data, head_ext} = head;

  // A full FIFO still accepts a frame when the scheduler pops in the same cycle.
  assign push = in_valid && !rst && ((fifo_count != FULL) || pop);
  assign drop = in_valid && (fifo_count == FULL) && !pop;

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_id, in_dlc, in_data, in_extended};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        fifo_count <= fifo_count + (AW+1)'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - (AW+1)'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state == LAUNCH) begin
        timer <= '0;
      end else if ((state == WAIT_FX) && !fx_features_ready && !timeout_hit) begin
        timer <= timer + TW'(1);
      end
    end
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH:   state_next = WAIT_FX;
      WAIT_FX: begin
        // Ready wins over a timeout landing in the same cycle.
        if (fx_features_ready) begin
          state_next = CLASSIFY;
        end else if (timer == T_LAST) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      CLASSIFY: state_next = WAIT_CLS;
      WAIT_CLS: begin
        if (cls_done) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // ----------------------------------------------------------- output logic
  always_comb begin
    fv_next   = (state == LAUNCH);
    cls_next  = (state == CLASSIFY);
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fx_can_id         <= '0;
      fx_can_dlc        <= '0;
      fx_can_data       <= '0;
      fx_frame_extended <= 1'b0;
      fx_frame_valid    <= 1'b0;
      cls_start         <= 1'b0;
      sched_busy        <= 1'b0;
      err_timeout       <= 1'b0;
      timeout_cnt       <= '0;
    end else begin
      fx_frame_valid <= fv_next;
      cls_start      <= cls_next;
      sched_busy     <= busy_next;
      err_timeout    <= timeout_hit;
      if (timeout_hit && (timeout_cnt != '1)) begin
        timeout_cnt <= timeout_cnt + CNT_W'(1);
      end
      if (pop) begin
        fx_can_id         <= head_ext ? head_id : {18'b0, head_id[10:0]};
        fx_can_dlc        <= (head_dlc > 4'd8) ? 4'd8 : head_dlc;
        fx_can_data       <= head_data;
        fx_frame_extended <= head_ext;
      end
    end
  end

endmodule

// File: tb/tb_can_fx_scheduler.sv
// Self-checking bench for can_fx_scheduler: table of normalisation vectors
// plus directed sequences for latency, timeout, overflow, reset and
// push-while-full corner cases.
module tb_can_fx_scheduler;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int CNT_W          = 16;
  localparam int CW             = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [28:0]       in_id = '0;
  logic [3:0]        in_dlc = '0;
  logic [63:0]       in_data = '0;
  logic              in_extended = 1'b0;
  logic [28:0]       fx_can_id;
  logic [3:0]        fx_can_dlc;
  logic [63:0]       fx_can_data;
  logic              fx_frame_extended;
  logic              fx_frame_valid;
  logic              fx_features_ready;
  logic              cls_start;
  logic              cls_done;
  logic              sched_busy;
  logic [CW-1:0]     fifo_count;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  timeout_cnt;
  logic              err_timeout;

  logic rdy_auto = 1'b0, rdy_man = 1'b0;
  logic done_auto = 1'b0, done_man = 1'b0;
  assign fx_features_ready = rdy_auto | rdy_man;
  assign cls_done          = done_auto | done_man;

  always #5 clk = ~clk;

  can_fx_scheduler #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_id            (in_id),
    .in_dlc           (in_dlc),
    .in_data          (in_data),
    .in_extended      (in_extended),
    .fx_can_id        (fx_can_id),
    .fx_can_dlc       (fx_can_dlc),
    .fx_can_data      (fx_can_data),
    .fx_frame_extended(fx_frame_extended),
    .fx_frame_valid   (fx_frame_valid),
    .fx_features_ready(fx_features_ready),
    .cls_start        (cls_start),
    .cls_done         (cls_done),
    .sched_busy       (sched_busy),
    .fifo_count       (fifo_count),
    .drop_cnt         (drop_cnt),
    .timeout_cnt      (timeout_cnt),
    .err_timeout      (err_timeout)
  );

  // Extractor / classifier responder. Delay 0 means "never respond".
  int rdy_delay  = 2;
  int done_delay = 1;
  int rcnt = 0, dcnt = 0;
  int n_cls = 0;
  logic [28:0] launched[$];

  always @(negedge clk) begin
    rdy_auto  = 1'b0;
    done_auto = 1'b0;
    if (rst) begin
      rcnt = 0;
      dcnt = 0;
    end else begin
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) rdy_auto = 1'b1;
      end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) done_auto = 1'b1;
      end
      if (fx_frame_valid) begin
        launched.push_back(fx_can_id);
        if (rdy_delay > 0) rcnt = rdy_delay;
      end
      if (cls_start) begin
        n_cls++;
        if (done_delay > 0) dcnt = done_delay;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [28:0] id, input logic [3:0] dlc,
                       input logic [63:0] data, input logic ext);
    in_valid    = 1'b1;
    in_id       = id;
    in_dlc      = dlc;
    in_data     = data;
    in_extended = ext;
  endtask

  // Presents one frame for exactly one sampling edge; returns at the
  // negedge following that edge.
  task automatic send(input logic [28:0] id, input logic [3:0] dlc,
                      input logic [63:0] data, input logic ext);
    @(negedge clk);
    drive(id, dlc, data, ext);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_fv(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc && !fx_frame_valid; i++) @(negedge clk);
    check(name, 64'(fx_frame_valid), 64'd1);
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc && !(sched_busy == 1'b0 && fifo_count == '0); i++)
      @(negedge clk);
    check(name, {sched_busy, fifo_count}, '0);
  endtask

  typedef struct {
    logic [28:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        ext;
    logic [28:0] exp_id;
    logic [3:0]  exp_dlc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int c0, base, first_err, err_hits;
    logic seen;

    vecs[0] = '{29'h1FFFF7A,  4'd12, 64'h0102030405060708, 1'b0, 29'h000077A,  4'd8};
    vecs[1] = '{29'h1FFFFFFF, 4'd15, 64'hFFFFFFFFFFFFFFFF, 1'b1, 29'h1FFFFFFF, 4'd8};
    vecs[2] = '{29'h00005A5,  4'd8,  64'hDEADBEEFCAFEF00D, 1'b0, 29'h00005A5,  4'd8};
    vecs[3] = '{29'h12345678, 4'd9,  64'h0000000000000001, 1'b0, 29'h0000678,  4'd8};
    vecs[4] = '{29'h0ABCDEF1, 4'd0,  64'h8000000000000000, 1'b1, 29'h0ABCDEF1, 4'd0};
    vecs[5] = '{29'h00007FF,  4'd7,  64'h55AA55AA55AA55AA, 1'b0, 29'h00007FF,  4'd7};

    // Reset: in_valid during the last reset cycle must be ignored.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    drive(29'h123, 4'd3, 64'h1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_busy", 64'(sched_busy), 64'd0);
    check("rst_fv_cls_err", {fx_frame_valid, cls_start, err_timeout}, 64'd0);
    check("rst_counters", {drop_cnt, timeout_cnt}, 64'd0);
    check("rst_fx_id", 64'(fx_can_id), 64'd0);
    check("rst_fx_dlc", 64'(fx_can_dlc), 64'd0);
    check("rst_fx_data", fx_can_data, 64'd0);
    repeat (3) @(negedge clk);
    check("rst_in_valid_ignored", 64'(fifo_count), 64'd0);

    // Single extended frame, latency and pulse shape.
    rdy_delay  = 5;
    done_delay = 3;
    c0 = n_cls;
    send(29'h1AB, 4'd8, 64'h8416690D00000000, 1'b1);
    check("t1_fv_edgeN", 64'(fx_frame_valid), 64'd0);
    @(negedge clk);
    check("t1_fv_edgeN1", 64'(fx_frame_valid), 64'd0);
    check("t1_busy", 64'(sched_busy), 64'd1);
    @(negedge clk);
    check("t1_fv_edgeN2", 64'(fx_frame_valid), 64'd1);
    check("t1_id", 64'(fx_can_id), 64'h1AB);
    check("t1_dlc", 64'(fx_can_dlc), 64'd8);
    check("t1_data", fx_can_data, 64'h8416690D00000000);
    check("t1_ext", 64'(fx_frame_extended), 64'd1);
    @(negedge clk);
    check("t1_fv_width", 64'(fx_frame_valid), 64'd0);
    wait_idle(60, "t1_idle");
    check("t1_cls_pulses", 64'(n_cls - c0), 64'd1);
    check("t1_drop", 64'(drop_cnt), 64'd0);

    // Normalisation table.
    rdy_delay  = 2;
    done_delay = 1;
    for (int unsigned v = 0; v < 6; v++) begin
      send(vecs[v].id, vecs[v].dlc, vecs[v].data, vecs[v].ext);
      wait_fv(8, $sformatf("vec%0d_fv", v));
      check($sformatf("vec%0d_id", v), 64'(fx_can_id), 64'(vecs[v].exp_id));
      check($sformatf("vec%0d_dlc", v), 64'(fx_can_dlc), 64'(vecs[v].exp_dlc));
      check($sformatf("vec%0d_data", v), fx_can_data, vecs[v].data);
      check($sformatf("vec%0d_ext", v), 64'(fx_frame_extended), 64'(vecs[v].ext));
      wait_idle(40, $sformatf("vec%0d_idle", v));
    end

    // Extractor timeout; second frame queued during WAIT_FX.
    rdy_delay  = 0;
    done_delay = 1;
    c0 = n_cls;
    send(29'h100, 4'd2, 64'h100, 1'b1);
    wait_fv(8, "to_fv_a");
    first_err = -1;
    err_hits  = 0;
    for (int i = 1; i <= TIMEOUT_CYCLES + 1; i++) begin
      @(negedge clk);
      if (i == 1) drive(29'h200, 4'd3, 64'h200, 1'b1);
      if (i == 2) in_valid = 1'b0;
      if (err_timeout) begin
        err_hits++;
        if (first_err < 0) first_err = i;
      end
    end
    check("to_err_offset", 64'(first_err), 64'(TIMEOUT_CYCLES));
    check("to_err_pulses", 64'(err_hits), 64'd1);
    check("to_cnt", 64'(timeout_cnt), 64'd1);
    rdy_delay = 2;
    wait_fv(5, "to_fv_b");
    check("to_id_b", 64'(fx_can_id), 64'h200);
    check("to_no_cls", 64'(n_cls - c0), 64'd0);
    wait_idle(40, "to_idle");

    // Burst of 6 with slow extractor: frame 6 dropped, order preserved.
    rdy_delay  = 20;
    done_delay = 1;
    base = launched.size();
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(29'h301 + 29'(k), 4'd1, 64'(k), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("burst_drop", 64'(drop_cnt), 64'd1);
    check("burst_count", 64'(fifo_count), 64'd4);
    wait_idle(400, "burst_idle");
    check("burst_launches", 64'(launched.size() - base), 64'd5);
    for (int k = 0; k < 5; k++)
      check($sformatf("burst_order%0d", k), 64'(launched[base + k]), 64'(29'h301 + 29'(k)));

    // Reset during WAIT_CLS with two frames queued.
    rdy_delay  = 1;
    done_delay = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(29'h401 + 29'(k), 4'd1, 64'(k), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rstw_busy_before", 64'(sched_busy), 64'd1);
    check("rstw_count_before", 64'(fifo_count), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_count", 64'(fifo_count), 64'd0);
    check("rstw_busy", 64'(sched_busy), 64'd0);
    check("rstw_counters", {drop_cnt, timeout_cnt}, 64'd0);
    check("rstw_pulses", {fx_frame_valid, cls_start, err_timeout}, 64'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (fx_frame_valid || cls_start) seen = 1'b1;
    end
    check("rstw_quiet", 64'(seen), 64'd0);
    done_delay = 1;
    send(29'h4AA, 4'd4, 64'h4AA, 1'b1);
    wait_fv(8, "rstw_new_fv");
    check("rstw_new_id", 64'(fx_can_id), 64'h4AA);
    wait_idle(40, "rstw_idle");

    // Push while full coinciding with a pop.
    rdy_delay  = 1;
    done_delay = 0;
    base = launched.size();
    send(29'h500, 4'd1, 64'h500, 1'b1);
    repeat (8) @(negedge clk);
    for (int unsigned k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(29'h500 + 29'(k), 4'd1, 64'(k), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pf_full", 64'(fifo_count), 64'd4);
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    drive(29'h505, 4'd1, 64'h505, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("pf_count", 64'(fifo_count), 64'd4);
    check("pf_drop", 64'(drop_cnt), 64'd0);
    done_delay = 1;
    wait_idle(300, "pf_idle");
    check("pf_launches", 64'(launched.size() - base), 64'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("pf_order%0d", k), 64'(launched[base + k]), 64'(29'h500 + 29'(k)));
    check("pf_drop_final", 64'(drop_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
